// File: rtl/sequenciador_pkg.sv
// Shared types and constants for the melody sequencer: FSM states, entry layout,
// note and tone codes understood by Circuito_topo.
package sequenciador_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap,
        StDone
    } estado_e;

    localparam int unsigned DUR_W   = 4;
    localparam int unsigned DUR_MSB = 7;
    localparam int unsigned DUR_LSB = 4;
    localparam int unsigned N1_BIT  = 3;
    localparam int unsigned N2_BIT  = 2;
    localparam int unsigned N3_BIT  = 1;
    localparam int unsigned D_BIT   = 0;

    localparam logic [2:0] NOTA_DESL = 3'd0;
    localparam logic [2:0] NOTA_LA   = 3'd1;
    localparam logic [2:0] NOTA_SI   = 3'd2;
    localparam logic [2:0] NOTA_DO   = 3'd3;
    localparam logic [2:0] NOTA_RE   = 3'd4;
    localparam logic [2:0] NOTA_MI   = 3'd5;
    localparam logic [2:0] NOTA_FA   = 3'd6;
    localparam logic [2:0] NOTA_SOL  = 3'd7;

    localparam logic TOM_ALTO  = 1'b0;
    localparam logic TOM_BAIXO = 1'b1;

    function automatic logic [DUR_W-1:0] duracao(input logic [7:0] entrada);
        return entrada[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/sequenciador_notas_if.sv
// Control, melody-write and note-output signals of the sequencer, bundled for
// connection between the control logic (master) and the sequencer (slave).
interface sequenciador_notas_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          start;
    logic          stop;
    logic          loop;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          N1;
    logic          N2;
    logic          N3;
    logic          D;
    logic          busy;
    logic          done;
    logic [AW-1:0] idx;

    modport master (
        output start, stop, loop, wr_en, wr_addr, wr_data,
        input  N1, N2, N3, D, busy, done, idx
    );

    modport slave (
        input  start, stop, loop, wr_en, wr_addr, wr_data,
        output N1, N2, N3, D, busy, done, idx
    );

endinterface

// File: rtl/divisor_batida.sv
// Beat prescaler: batida_o is high for one cycle every TICKS_PER_BEAT cycles,
// counted from the last synchronous clear.
module divisor_batida #(
    parameter int unsigned TICKS_PER_BEAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic batida_o
);
    localparam int unsigned TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TW-1:0] TOPO = TW'(TICKS_PER_BEAT - 1);

    logic [TW-1:0] tick_q, tick_d;

    always_comb begin
        tick_d = tick_q + TW'(1);
        if (clr_i || tick_q == TOPO) begin
            tick_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign batida_o = (tick_q == TOPO);

endmodule

// File: rtl/sequenciador_notas.sv
// Melody sequencer: plays entries from a writable memory onto N1/N2/N3/D, each for
// duration*TICKS_PER_BEAT cycles. Define SEQ_GAP_EN to insert a silent beat between notes.
module sequenciador_notas
    import sequenciador_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TICKS_PER_BEAT = 4
) (
    input logic                 clk,
    input logic                 rst,
    sequenciador_notas_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] ULTIMO = AW'(DEPTH - 1);

    estado_e          state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d, load_addr, nxt_idx;
    logic [3:0]       nota_q, nota_d;
    logic [DUR_W-1:0] dur_q, dur_d, beat_q, beat_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             load, div_clr, batida, fim_nota, prox_ok;
    logic [7:0]       mem_q [DEPTH];

    divisor_batida #(
        .TICKS_PER_BEAT(TICKS_PER_BEAT)
    ) u_divisor (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (div_clr),
        .batida_o(batida)
    );

    // Memory is not reset; reads below see the pre-write contents on a same-edge write.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign nxt_idx  = idx_q + AW'(1);
    assign prox_ok  = (idx_q != ULTIMO) && (duracao(mem_q[nxt_idx]) != '0);
    assign fim_nota = batida && (beat_q == dur_q - DUR_W'(1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        nota_d    = nota_q;
        dur_d     = dur_q;
        beat_d    = beat_q;
        load      = 1'b0;
        load_addr = idx_q;
        div_clr   = 1'b0;

        case (state_q)
            StIdle: begin
                idx_d   = '0;
                nota_d  = '0;
                beat_d  = '0;
                div_clr = 1'b1;
                if (bus.start) begin
                    if (duracao(mem_q[0]) != '0) begin
                        load      = 1'b1;
                        load_addr = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StPlay: begin
                if (fim_nota) begin
                    if (prox_ok || bus.loop) begin
`ifdef SEQ_GAP_EN
                        state_d = StGap;
                        nota_d  = '0;
                        idx_d   = prox_ok ? nxt_idx : '0;
                        div_clr = 1'b1;
`else
                        load      = 1'b1;
                        load_addr = prox_ok ? nxt_idx : '0;
`endif
                    end else begin
                        state_d = StDone;
                        nota_d  = '0;
                        idx_d   = '0;
                    end
                end else if (batida) begin
                    beat_d = beat_q + DUR_W'(1);
                end
            end
`ifdef SEQ_GAP_EN
            StGap: begin
                // idx already points at the entry to load; recheck it in case it was rewritten.
                if (batida) begin
                    if (duracao(mem_q[idx_q]) != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = StDone;
                        idx_d   = '0;
                    end
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            state_d = StPlay;
            idx_d   = load_addr;
            nota_d  = mem_q[load_addr][3:0];
            dur_d   = duracao(mem_q[load_addr]);
            beat_d  = '0;
            div_clr = 1'b1;
        end

        if (bus.stop) begin
            state_d = StIdle;
            idx_d   = '0;
            nota_d  = '0;
            beat_d  = '0;
            div_clr = 1'b1;
        end

        busy_d = (state_d == StPlay) || (state_d == StGap);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            nota_q  <= '0;
            dur_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nota_q  <= nota_d;
            dur_q   <= dur_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.N1   = nota_q[N1_BIT];
    assign bus.N2   = nota_q[N2_BIT];
    assign bus.N3   = nota_q[N3_BIT];
    assign bus.D    = nota_q[D_BIT];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.idx  = idx_q;

endmodule

// File: tb/tb_sequenciador_notas.sv
// Bench for sequenciador_notas: directed scenarios plus random traffic, checked every
// cycle against a countdown-based playback model, with a literal timeline for the basic melody.
module tb_sequenciador_notas;
    import sequenciador_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned T     = 2;
    localparam int unsigned AW    = 4;
`ifdef SEQ_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sequenciador_notas_if #(.DEPTH(DEPTH)) bus ();

    sequenciador_notas #(
        .DEPTH         (DEPTH),
        .TICKS_PER_BEAT(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Model: mode 0 idle, 1 play, 2 gap, 3 done; m_rem = cycles left in current note/gap.
    int         m_mode = 0;
    int         m_idx  = 0;
    int         m_rem  = 0;
    int         m_pend = 0;
    logic [3:0] m_note = 4'h0;
    logic [7:0] mem_m [DEPTH];
    int         edges  = 0;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         chk_en  = 1'b0;
    int         lit_base = -1;
    logic [5:0] lit_exp [14];

    function automatic int dur_of(input logic [7:0] e);
        return int'(e[7:4]);
    endfunction

    task automatic m_load(input int a);
        m_mode = 1;
        m_idx  = a;
        m_note = mem_m[a][3:0];
        m_rem  = dur_of(mem_m[a]) * int'(T);
    endtask

    task automatic m_done();
        m_mode = 3;
        m_idx  = 0;
        m_note = 4'h0;
    endtask

    task automatic m_next(input int a);
        if (GAP_EN) begin
            m_mode = 2;
            m_pend = a;
            m_idx  = a;
            m_rem  = int'(T);
            m_note = 4'h0;
        end else begin
            m_load(a);
        end
    endtask

    always @(posedge clk) begin
        edges++;
        if (rst || bus.stop) begin
            m_mode = 0;
            m_idx  = 0;
            m_note = 4'h0;
        end else begin
            case (m_mode)
                0: if (bus.start) begin
                    if (dur_of(mem_m[0]) != 0) m_load(0);
                    else m_done();
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        if (m_idx < int'(DEPTH) - 1 && dur_of(mem_m[m_idx + 1]) != 0)
                            m_next(m_idx + 1);
                        else if (bus.loop) m_next(0);
                        else m_done();
                    end
                end
                2: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        if (dur_of(mem_m[m_pend]) != 0) m_load(m_pend);
                        else m_done();
                    end
                end
                default: begin
                    m_mode = 0;
                    m_idx  = 0;
                    m_note = 4'h0;
                end
            endcase
        end
        if (bus.wr_en) mem_m[bus.wr_addr] = bus.wr_data;
    end

    always @(negedge clk) begin
        logic [9:0] dut_v;
        logic [9:0] exp_v;
        logic [5:0] mod6;
        int off;
        if (chk_en) begin
            dut_v = {bus.busy, bus.done, bus.N1, bus.N2, bus.N3, bus.D, bus.idx};
            exp_v = {(m_mode == 1 || m_mode == 2), (m_mode == 3), m_note, AW'(m_idx)};
            n_tests++;
            if (dut_v !== exp_v) begin
                n_fail++;
                $display("FAIL model t=%0d: got busy=%b done=%b note=%b idx=%0d, want busy=%b done=%b note=%b idx=%0d",
                         edges, dut_v[9], dut_v[8], dut_v[7:4], dut_v[3:0],
                         exp_v[9], exp_v[8], exp_v[7:4], exp_v[3:0]);
            end
            off = edges - lit_base;
            if (lit_base >= 0 && off >= 0 && off < 14) begin
                n_tests++;
                if (dut_v[9:4] !== lit_exp[off]) begin
                    n_fail++;
                    $display("FAIL basic_dut k+%0d: got %b want %b", off, dut_v[9:4], lit_exp[off]);
                end
                mod6 = exp_v[9:4];
                n_tests++;
                if (mod6 !== lit_exp[off]) begin
                    n_fail++;
                    $display("FAIL basic_model k+%0d: got %b want %b", off, mod6, lit_exp[off]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        // {busy, done, N1 N2 N3 D} from the start edge k onward.
`ifdef SEQ_GAP_EN
        lit_exp = '{6'b100010, 6'b100010, 6'b100000, 6'b100000, 6'b100111, 6'b100111,
                    6'b100111, 6'b100111, 6'b100000, 6'b100000, 6'b101110, 6'b101110,
                    6'b010000, 6'b000000};
`else
        lit_exp = '{6'b100010, 6'b100010, 6'b100111, 6'b100111, 6'b100111, 6'b100111,
                    6'b101110, 6'b101110, 6'b010000, 6'b000000, 6'b000000, 6'b000000,
                    6'b000000, 6'b000000};
`endif
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        tick(2);
        chk_en = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) wr(i, 8'h00);
        rst = 1'b0;
        wr(0, {4'd1, NOTA_LA, TOM_ALTO});
        wr(1, {4'd2, NOTA_DO, TOM_BAIXO});
        wr(2, {4'd1, NOTA_SOL, TOM_ALTO});
        wr(3, 8'h00);
        tick(2);

        // Basic melody with literal timeline.
        lit_base = edges + 1;
        pulse_start();
        tick(16);

        // Loop, then release loop so it ends.
        bus.loop = 1'b1;
        pulse_start();
        tick(20);
        bus.loop = 1'b0;
        tick(12);

        // Stop during the second note, then replay.
        pulse_start();
        tick(3);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        tick(3);
        pulse_start();
        tick(14);

        // Start and stop together in idle.
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        tick(3);

        // Empty melody.
        wr(0, 8'h00);
        pulse_start();
        tick(4);
        wr(0, 8'h12);

        // Reset during playback.
        pulse_start();
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);

        // Start held while busy.
        bus.start = 1'b1;
        tick(8);
        bus.start = 1'b0;
        tick(14);

        // Write to the playing entry and to the next one.
        pulse_start();
        wr(1, 8'h3A);
        wr(0, 8'h2C);
        tick(20);

        // Random traffic; entry 0 always keeps a nonzero duration.
        for (int c = 0; c < 3000; c++) begin
            bus.start = ($urandom_range(0, 15) == 0);
            bus.stop  = ($urandom_range(0, 79) == 0);
            bus.loop  = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            bus.wr_en = ($urandom_range(0, 7) == 0);
            bus.wr_addr = AW'($urandom_range(0, DEPTH - 1));
            d = 8'($urandom);
            if (bus.wr_addr == '0) d[7:4] = 4'($urandom_range(1, 3));
            else d[7:4] = 4'($urandom_range(0, 3));
            bus.wr_data = d;
            tick(1);
        end
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        bus.wr_en = 1'b0;
        rst = 1'b0;
        tick(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
